// File: rtl/com_pkg.sv
`timescale 1ns/1ps
// com_pkg
// Shared types and default parameters for the LVDS readout-link responder
// (com_readout_slave) and its helpers.
//   com_state_t   : top-level FSM state, also exported on the debug port
//   CMD_READ_DEF  : read command byte (six 1s, two 0s, MSB first)
//   WORDS_DEF     : bytes per block
//   IDLE_CYC_DEF  : clk cycles without an sck edge before a transfer aborts
//   CNT_W_DEF     : width of the FIFO fill-level input
package com_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } com_state_t;

  localparam logic [7:0] CMD_READ_DEF = 8'hFC;
  localparam int         WORDS_DEF    = 1024;
  localparam int         IDLE_CYC_DEF = 256;
  localparam int         CNT_W_DEF    = 11;

endpackage

// File: rtl/com_sck_sync.sv
`timescale 1ns/1ps
// com_sck_sync
// Brings the host's sck/mosi pins into the clk domain and turns sck into
// single-cycle rise/fall pulses.
//   clk_i, rst_ni  : fabric clock, asynchronous active-low reset
//   sck_i, mosi_i  : raw host pins (asynchronous to clk_i)
//   sck_rise_o     : one-cycle pulse, 3 clk after an sck rising pin edge
//   sck_fall_o     : one-cycle pulse, 3 clk after an sck falling pin edge
//   mosi_o         : mosi sampled in step with the sck pulses, so mosi_o is
//                    the value the pin had when the matching sck edge arrived
module com_sck_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sck_i,
  input  logic mosi_i,
  output logic sck_rise_o,
  output logic sck_fall_o,
  output logic mosi_o
);

  logic [1:0] sck_sync_q;
  logic [1:0] mosi_sync_q;
  logic       sck_prev_q;
  logic       rise_q;
  logic       fall_q;
  logic       mosi_q;

  // Stage 1/2: metastability filter. Stage 3: registered edge pulses, which
  // gives the fixed 3-cycle pin-to-pulse latency the timing budget relies on.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sck_sync_q  <= 2'b00;
      mosi_sync_q <= 2'b00;
      sck_prev_q  <= 1'b0;
      rise_q      <= 1'b0;
      fall_q      <= 1'b0;
      mosi_q      <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[0], sck_i};
      mosi_sync_q <= {mosi_sync_q[0], mosi_i};
      sck_prev_q  <= sck_sync_q[1];
      rise_q      <= sck_sync_q[1] & ~sck_prev_q;
      fall_q      <= ~sck_sync_q[1] & sck_prev_q;
      mosi_q      <= mosi_sync_q[1];
    end
  end

  assign sck_rise_o = rise_q;
  assign sck_fall_o = fall_q;
  assign mosi_o     = mosi_q;

endmodule

// File: rtl/com_readout_slave.sv
`timescale 1ns/1ps
// com_readout_slave
// FPGA-side responder for the LVDS readout link. Raises rdy once a full block
// is buffered, accepts the host's command byte on mosi/sck, then shifts the
// block out MSB-first on miso (host samples on sck rise, data moves on fall).
// Ports:
//   clk, nreset                 : fabric clock, asynchronous active-low reset
//   sck, mosi / miso, rdy       : link pins (in / registered out)
//   fifo_data, fifo_empty,
//   fifo_count / fifo_rd        : show-ahead byte FIFO and its pop strobe
//   busy, underrun, abort,
//   blocks_sent                 : status (underrun sticky, cleared by underrun_clr)
//   dbg_state                   : current FSM state for observation
// FIFO handshake: fifo_data is valid whenever fifo_empty is 0; a cycle with
// fifo_rd=1 consumes exactly that head byte at the next clk edge. fifo_rd is
// only ever raised while fifo_empty is 0.
module com_readout_slave
  import com_pkg::*;
#(
  parameter int         WORDS    = WORDS_DEF,
  parameter logic [7:0] CMD_READ = CMD_READ_DEF,
  parameter int         IDLE_CYC = IDLE_CYC_DEF,
  parameter int         CNT_W    = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             sck,
  input  logic             mosi,
  output logic             miso,
  output logic             rdy,
  input  logic [7:0]       fifo_data,
  input  logic             fifo_empty,
  input  logic [CNT_W-1:0] fifo_count,
  output logic             fifo_rd,
  output logic             busy,
  output logic             underrun,
  input  logic             underrun_clr,
  output logic             abort,
  output logic [15:0]      blocks_sent,
  output com_state_t       dbg_state
);

  localparam int BC_W = $clog2(WORDS + 1);
  localparam int IC_W = $clog2(IDLE_CYC + 1);

  com_state_t      state_q, state_d;
  logic [7:0]      cmd_q, cmd_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;   // command bits in CMD, sampled bits in SEND
  logic [BC_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [7:0]      shreg_q, shreg_d;
  logic [IC_W-1:0] idle_cnt_q, idle_cnt_d;
  logic            rdy_q, rdy_d;
  logic            miso_q, miso_d;
  logic            busy_q, busy_d;
  logic            underrun_q, underrun_d;
  logic            abort_q, abort_d;
  logic [15:0]     blocks_q, blocks_d;

  logic sck_rise, sck_fall, mosi_s;
  logic timed, timeout, load, underrun_set, fifo_rd_d;

  com_sck_sync u_sync (
    .clk_i      (clk),
    .rst_ni     (nreset),
    .sck_i      (sck),
    .mosi_i     (mosi),
    .sck_rise_o (sck_rise),
    .sck_fall_o (sck_fall),
    .mosi_o     (mosi_s)
  );

  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    bit_cnt_d    = bit_cnt_q;
    byte_cnt_d   = byte_cnt_q;
    shreg_d      = shreg_q;
    idle_cnt_d   = '0;
    rdy_d        = rdy_q;
    blocks_d     = blocks_q;
    abort_d      = 1'b0;
    miso_d       = 1'b0;
    load         = 1'b0;
    underrun_set = 1'b0;
    fifo_rd_d    = 1'b0;
    timeout      = 1'b0;

    // Watchdog runs only while the host is mid-transfer.
    timed = ((state_q == CMD) && (bit_cnt_q != 3'd0)) || (state_q == SEND);
    if (timed && !(sck_rise || sck_fall)) begin
      if (idle_cnt_q == IC_W'(IDLE_CYC - 1)) timeout = 1'b1;
      else                                   idle_cnt_d = idle_cnt_q + IC_W'(1);
    end

    case (state_q)
      IDLE: begin
        rdy_d     = 1'b0;
        bit_cnt_d = 3'd0;
        if (fifo_count >= CNT_W'(WORDS)) begin
          state_d = CMD;
          rdy_d   = 1'b1;
        end
      end
      CMD: begin
        if (sck_rise) begin
          cmd_d     = {cmd_q[6:0], mosi_s};
          bit_cnt_d = bit_cnt_q + 3'd1;   // wraps to 0 after the 8th bit
          if ((bit_cnt_q == 3'd7) && (cmd_d == CMD_READ)) begin
            rdy_d      = 1'b0;
            load       = 1'b1;
            byte_cnt_d = '0;
            state_d    = SEND;
          end
        end
      end
      SEND: begin
        // The fall that follows the 8th rise (of the command or of a data
        // byte) arrives after the next byte is already loaded; bit_cnt is 0
        // then, so that fall must not shift the fresh MSB away.
        if (sck_fall && (bit_cnt_q != 3'd0)) shreg_d = {shreg_q[6:0], 1'b0};
        if (sck_rise) begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            byte_cnt_d = byte_cnt_q + BC_W'(1);
            if (byte_cnt_d == BC_W'(WORDS)) state_d = DONE;
            else                            load    = 1'b1;
          end
        end
      end
      DONE: begin
        blocks_d = blocks_q + 16'd1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      if (fifo_empty) begin
        shreg_d      = 8'h00;
        underrun_set = 1'b1;
      end else begin
        shreg_d   = fifo_data;
        fifo_rd_d = 1'b1;
      end
    end

    // A timeout only fires in a cycle with no sck edge, so it never
    // coincides with a load; whatever was popped is simply dropped.
    if (timeout) begin
      state_d   = IDLE;
      abort_d   = 1'b1;
      rdy_d     = 1'b0;
      bit_cnt_d = 3'd0;
    end

    if (state_d == SEND) miso_d = shreg_d[7];
    busy_d     = ((state_d == CMD) && (bit_cnt_d != 3'd0)) || (state_d == SEND);
    underrun_d = underrun_set | (underrun_q & ~underrun_clr);
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q    <= IDLE;
      cmd_q      <= 8'h00;
      bit_cnt_q  <= 3'd0;
      byte_cnt_q <= '0;
      shreg_q    <= 8'h00;
      idle_cnt_q <= '0;
      rdy_q      <= 1'b0;
      miso_q     <= 1'b0;
      busy_q     <= 1'b0;
      underrun_q <= 1'b0;
      abort_q    <= 1'b0;
      blocks_q   <= 16'd0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      shreg_q    <= shreg_d;
      idle_cnt_q <= idle_cnt_d;
      rdy_q      <= rdy_d;
      miso_q     <= miso_d;
      busy_q     <= busy_d;
      underrun_q <= underrun_d;
      abort_q    <= abort_d;
      blocks_q   <= blocks_d;
    end
  end

  assign miso        = miso_q;
  assign rdy         = rdy_q;
  assign fifo_rd     = fifo_rd_d;
  assign busy        = busy_q;
  assign underrun    = underrun_q;
  assign abort       = abort_q;
  assign blocks_sent = blocks_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_com_readout_slave.sv
`timescale 1ns/1ps
// tb_com_readout_slave
// Directed bench for com_readout_slave: host SPI-style driver, show-ahead
// FIFO model holding a byte ramp, a block-level expectation model and one
// compare process. Blocks are shortened to 64 bytes to keep run time small.
module tb_com_readout_slave;
  import com_pkg::*;

  localparam int WORDS_TB = 64;
  localparam int CNT_W_TB = 11;

  // ---------------- clock / reset ----------------
  logic clk;
  initial begin
    clk = 1'b0;
    forever #2 clk = ~clk;
  end

  logic                nreset, sck, mosi, miso, rdy;
  logic [7:0]          fifo_data;
  logic                fifo_empty, fifo_rd, busy, underrun, underrun_clr, abort;
  logic [CNT_W_TB-1:0] fifo_count;
  logic [15:0]         blocks_sent;
  com_state_t          dbg_state;

  com_readout_slave #(
    .WORDS    (WORDS_TB),
    .CMD_READ (8'hFC),
    .IDLE_CYC (256),
    .CNT_W    (CNT_W_TB)
  ) dut (
    .clk          (clk),
    .nreset       (nreset),
    .sck          (sck),
    .mosi         (mosi),
    .miso         (miso),
    .rdy          (rdy),
    .fifo_data    (fifo_data),
    .fifo_empty   (fifo_empty),
    .fifo_count   (fifo_count),
    .fifo_rd      (fifo_rd),
    .busy         (busy),
    .underrun     (underrun),
    .underrun_clr (underrun_clr),
    .abort        (abort),
    .blocks_sent  (blocks_sent),
    .dbg_state    (dbg_state)
  );

  // ---------------- FIFO model (show-ahead) ----------------
  logic [7:0] fmem [0:4095];
  int rd_ptr = 0;
  int wr_ptr = 0;
  int pops   = 0;
  int aborts = 0;

  assign fifo_data  = fmem[12'(rd_ptr)];
  assign fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (fifo_rd) begin
      rd_ptr <= rd_ptr + 1;
      pops   <= pops + 1;
    end
    if (abort) aborts <= aborts + 1;
  end

  // ---------------- scoreboard ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic [7:0] rx_blk [0:WORDS_TB-1];
  logic       chk_zero = 1'b0;
  logic [7:0] cmp_got, cmp_exp;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Compare process: host-captured bytes against the model, plus per-cycle
  // rules (never pop an empty FIFO; miso quiet when no block is selected).
  always @(negedge clk) begin
    if (got_q.size() != 0) begin
      cmp_got = got_q.pop_front();
      if (exp_q.size() == 0) begin
        chk("unexpected_byte", 32'(cmp_got), 32'hFFFF_FFFF);
      end else begin
        cmp_exp = exp_q.pop_front();
        chk("miso_byte", 32'(cmp_got), 32'(cmp_exp));
      end
    end
    if (fifo_rd)  chk("pop_nonempty", 32'(fifo_empty), 32'd0);
    if (chk_zero) chk("miso_quiet", 32'(miso), 32'd0);
  end

  // Model: a block delivers the FIFO bytes in order while they last, 0x00 after.
  task automatic model_block(input int n);
    int avail = wr_ptr - rd_ptr;
    for (int k = 0; k < n; k++)
      exp_q.push_back((k < avail) ? fmem[12'(rd_ptr + k)] : 8'h00);
  endtask

  // ---------------- host driver tasks ----------------
  // Mode-0 host: mosi changes while sck is low, miso sampled just before rise.
  task automatic xfer_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    @(posedge clk);
    #1;
    for (int i = 7; i > 7 - nbits; i--) begin
      mosi  = tx[i];
      #20;
      rx[i] = miso;
      sck   = 1'b1;
      #20;
      sck   = 1'b0;
    end
    mosi = 1'b0;
  endtask

  task automatic host_byte(input logic [7:0] tx, output logic [7:0] rx);
    xfer_bits(tx, 8, rx);
    #100;
  endtask

  task automatic read_block(input int n);
    logic [7:0] r;
    for (int k = 0; k < n; k++) begin
      host_byte(8'h00, r);
      rx_blk[k] = r;
      got_q.push_back(r);
    end
  endtask

  // watchdog
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  logic [7:0] rx, b5;
  int p0, a0;

  initial begin
    nreset       = 1'b0;
    sck          = 1'b0;
    mosi         = 1'b0;
    underrun_clr = 1'b0;
    fifo_count   = 11'd2000;
    for (int i = 0; i < 4096; i++) fmem[i] = i[7:0];
    wr_ptr = 4000;

    // Reset: outputs stay 0 while sck toggles under reset.
    repeat (6) begin
      #7 sck = ~sck;
      chk("rst_outputs", {26'd0, miso, rdy, busy, abort, underrun, fifo_rd}, 32'd0);
    end
    sck = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_blocks", 32'(blocks_sent), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    fifo_count = 11'd0;
    nreset     = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("rst_rdy_empty", 32'(rdy), 32'd0);

    // Threshold.
    fifo_count = 11'd63;
    repeat (10) @(posedge clk);
    #1;
    chk("thr_63_rdy", 32'(rdy), 32'd0);
    fifo_count = 11'd64;
    repeat (2) @(posedge clk);
    #1;
    chk("thr_64_rdy", 32'(rdy), 32'd1);
    chk("thr_64_busy", 32'(busy), 32'd0);

    // Full block.
    p0 = pops;
    model_block(WORDS_TB);
    host_byte(8'hFC, rx);
    chk("b1_rdy_after_cmd", 32'(rdy), 32'd0);
    chk("b1_busy", 32'(busy), 32'd1);
    read_block(WORDS_TB);
    chk("b1_pops", 32'(pops - p0), 32'(WORDS_TB));
    chk("b1_blocks", 32'(blocks_sent), 32'd1);
    chk("b1_underrun", 32'(underrun), 32'd0);
    chk("b1_first", 32'(rx_blk[0]), 32'h00);
    chk("b1_last", 32'(rx_blk[WORDS_TB-1]), 32'h3F);
    chk("b1_rdy_rearmed", 32'(rdy), 32'd1);

    // Wrong command, then a good block.
    chk_zero = 1'b1;
    p0 = pops;
    host_byte(8'hF0, rx);
    chk("wc_miso", 32'(rx), 32'd0);
    chk("wc_rdy", 32'(rdy), 32'd1);
    chk("wc_pops", 32'(pops - p0), 32'd0);
    chk("wc_busy", 32'(busy), 32'd0);
    chk_zero = 1'b0;
    p0 = pops;
    model_block(WORDS_TB);
    host_byte(8'hFC, rx);
    read_block(WORDS_TB);
    chk("b2_pops", 32'(pops - p0), 32'(WORDS_TB));
    chk("b2_blocks", 32'(blocks_sent), 32'd2);
    chk("b2_first", 32'(rx_blk[0]), 32'h40);
    chk("b2_last", 32'(rx_blk[WORDS_TB-1]), 32'h7F);

    // Underrun: only 40 bytes left in the FIFO.
    wr_ptr = rd_ptr + 40;
    p0 = pops;
    model_block(WORDS_TB);
    chk("ur_pre", 32'(underrun), 32'd0);
    host_byte(8'hFC, rx);
    read_block(WORDS_TB);
    chk("ur_pops", 32'(pops - p0), 32'd40);
    chk("ur_flag", 32'(underrun), 32'd1);
    chk("ur_last_real", 32'(rx_blk[39]), 32'hA7);
    chk("ur_first_zero", 32'(rx_blk[40]), 32'h00);
    chk("ur_blocks", 32'(blocks_sent), 32'd3);
    repeat (20) @(posedge clk);
    #1;
    chk("ur_sticky", 32'(underrun), 32'd1);
    underrun_clr = 1'b1;
    @(posedge clk);
    #1;
    underrun_clr = 1'b0;
    chk("ur_cleared", 32'(underrun), 32'd0);
    wr_ptr = rd_ptr + 3000;

    // Abort: host stalls after 3 bits of byte 10.
    p0 = pops;
    a0 = aborts;
    model_block(10);
    host_byte(8'hFC, rx);
    read_block(10);
    xfer_bits(8'h00, 3, rx);
    chk("ab_busy_pre", 32'(busy), 32'd1);
    repeat (300) @(posedge clk);
    #1;
    chk("ab_pulses", 32'(aborts - a0), 32'd1);
    chk("ab_pops", 32'(pops - p0), 32'd11);
    chk("ab_busy_post", 32'(busy), 32'd0);
    chk("ab_rdy_rearmed", 32'(rdy), 32'd1);
    chk("ab_blocks", 32'(blocks_sent), 32'd3);
    chk("ab_miso", 32'(miso), 32'd0);

    // Reset in the middle of byte 5.
    b5 = fmem[12'(rd_ptr + 5)];
    model_block(5);
    host_byte(8'hFC, rx);
    read_block(5);
    xfer_bits(8'h00, 3, rx);
    #20;
    chk("rs_miso_pre", 32'(miso), 32'(b5[4]));
    chk("rs_busy_pre", 32'(busy), 32'd1);
    nreset = 1'b0;
    #1;
    chk("rs_outputs", {26'd0, miso, rdy, busy, abort, underrun, fifo_rd}, 32'd0);
    chk("rs_blocks", 32'(blocks_sent), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    nreset = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("rs_rdy_after", 32'(rdy), 32'd1);
    chk("rs_busy_after", 32'(busy), 32'd0);
    chk("rs_state_after", 32'(dbg_state), 32'(CMD));

    repeat (4) @(negedge clk);
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
